// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC, next-PC selection, req/ack fetch handshake and decoded instruction fields.
// Optional misaligned-target trap enabled by defining IFETCH_ALIGN_CHECK_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_READY,
    S_ERR
  } state_t;

  state_t      state;
  logic [31:0] npc;
  logic [31:0] br_offset;

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm16    = instr[15:0];
  assign pc_plus4 = pc + 32'd4;

  // The request drops combinationally during reset so an in-flight fetch is abandoned immediately.
  assign imem_req  = (state == S_FETCH) && !rst;
  assign imem_addr = pc;

  always_comb begin
    br_offset = {{14{imm16[15]}}, imm16, 2'b00};
    npc       = pc_plus4;
    case (npc_sel)
      2'b00:   npc = pc_plus4;
      2'b01:   npc = branch_taken ? (pc_plus4 + br_offset) : pc_plus4;
      2'b10:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: npc = jr_target;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      addr_err    <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_READY;
          end
        end
        S_READY: begin
          if (advance) begin
            instr_valid <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            pc <= npc;
            if (npc[1:0] != 2'b00) begin
              addr_err <= 1'b1;
              state    <= S_ERR;
            end else begin
              state    <= S_FETCH;
            end
`else
            // Without the trap a misaligned target is silently truncated to a word address.
            pc    <= npc & ~32'h0000_0003;
            state <= S_FETCH;
`endif
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

`ifndef IFETCH_ALIGN_CHECK_EN
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by randomized traffic against a
// behavioural model of the fetch stage.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] pc, pc_plus4;
  logic        advance = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  bit          m_known = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_err;

  ifetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
    .pc(pc), .pc_plus4(pc_plus4),
    .advance(advance), .npc_sel(npc_sel), .branch_taken(branch_taken), .jr_target(jr_target),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  // Where the fetch should go next, computed from the current model instruction and select inputs.
  function automatic logic [31:0] modelTarget();
    logic [31:0] p4;
    int          off;
    p4  = m_pc + 32'd4;
    off = int'($signed(m_instr[15:0]));
    case (npc_sel)
      2'd0:    return p4;
      2'd1:    return branch_taken ? p4 + 32'(off * 4) : p4;
      2'd2:    return (p4 & 32'hF000_0000) | ({6'd0, m_instr[25:0]} << 2);
      default: return jr_target;
    endcase
  endfunction

  task automatic modelUpdate();
    logic [31:0] t;
    if (rst) begin
      m_known = 1'b1;
      m_pc    = RESET_PC;
      m_instr = 32'h0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else if (m_known && !m_err) begin
      if (!m_valid) begin
        if (imem_ack) begin
          m_instr = imem_rdata;
          m_valid = 1'b1;
        end
      end else if (advance) begin
        t       = modelTarget();
        m_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        m_pc = t;
        if (t % 4 != 0) m_err = 1'b1;
`else
        m_pc = t - (t % 4);
`endif
      end
    end
  endtask

  task automatic checkComb();
    if (m_known) begin
      checkValue("imem_req", 32'(imem_req), 32'(!m_valid && !m_err && !rst));
      checkValue("imem_addr", imem_addr, m_pc);
    end
  endtask

  task automatic checkOutput();
    if (m_known) begin
      checkComb();
      checkValue("instr_valid", 32'(instr_valid), 32'(m_valid));
      checkValue("instr", instr, m_instr);
      checkValue("pc", pc, m_pc);
      checkValue("pc_plus4", pc_plus4, m_pc + 32'd4);
      checkValue("op", 32'(op), m_instr >> 26);
      checkValue("rs", 32'(rs), (m_instr >> 21) & 32'h1F);
      checkValue("rt", 32'(rt), (m_instr >> 16) & 32'h1F);
      checkValue("rd", 32'(rd), (m_instr >> 11) & 32'h1F);
      checkValue("shamt", 32'(shamt), (m_instr >> 6) & 32'h1F);
      checkValue("funct", 32'(funct), m_instr & 32'h3F);
      checkValue("imm16", 32'(imm16), m_instr & 32'hFFFF);
      checkValue("addr_err", 32'(addr_err), 32'(m_err));
    end
  endtask

  // One clock: drive inputs, check combinational outputs before the edge, then check state after it.
  task automatic applyStimulus(input logic r, input logic a, input logic d, input logic [31:0] data,
                               input logic [1:0] sel, input logic tk, input logic [31:0] jt);
    rst          = r;
    imem_ack     = a;
    advance      = d;
    imem_rdata   = data;
    npc_sel      = sel;
    branch_taken = tk;
    jr_target    = jt;
    #1;
    checkComb();
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
  endtask

  task automatic ackWith(input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, d, 2'b00, 1'b0, 32'h0);
  endtask

  task automatic advanceWith(input logic [1:0] s, input logic t, input logic [31:0] j);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, s, t, j);
  endtask

  initial begin
    $display("[TB] start");

    // Reset, zero-wait fetch, sequential advance
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    checkValue("reset_pc", pc, 32'h0000_3000);
    checkValue("reset_instr", instr, 32'h0);
    checkValue("reset_valid", 32'(instr_valid), 32'h0);
    ackWith(32'h2401_0005);
    checkValue("t1_valid", 32'(instr_valid), 32'h1);
    checkValue("t1_op", 32'(op), 32'h09);
    checkValue("t1_rt", 32'(rt), 32'h1);
    checkValue("t1_imm16", 32'(imm16), 32'h5);
    advanceWith(2'b00, 1'b0, 32'h0);
    checkValue("t1_pc", pc, 32'h0000_3004);
    checkValue("t1_req", 32'(imem_req), 32'h1);

    // Branch taken and not taken with a negative offset
    ackWith(32'h1000_FFFE);
    advanceWith(2'b11, 1'b0, 32'h0000_3010);
    ackWith(32'h1000_FFFE);
    advanceWith(2'b01, 1'b1, 32'h0);
    checkValue("t2_taken_pc", pc, 32'h0000_300C);
    ackWith(32'h1000_FFFE);
    advanceWith(2'b11, 1'b0, 32'h0000_3010);
    ackWith(32'h1000_FFFE);
    advanceWith(2'b01, 1'b0, 32'h0);
    checkValue("t2_nottaken_pc", pc, 32'h0000_3014);

    // Jump and register jump
    ackWith(32'h0);
    advanceWith(2'b11, 1'b0, 32'h0000_3000);
    ackWith(32'h0800_0C10);
    advanceWith(2'b10, 1'b0, 32'h0);
    checkValue("t3_jump_pc", pc, 32'h0000_3040);
    ackWith(32'h0);
    advanceWith(2'b11, 1'b0, 32'h0040_0000);
    checkValue("t3_jr_pc", pc, 32'h0040_0000);

    // Delayed ack with advance during the wait, stray ack in READY, PC wrap
    idle();
    advanceWith(2'b00, 1'b0, 32'h0);
    idle();
    checkValue("t4_addr_hold", imem_addr, 32'h0040_0000);
    ackWith(32'h1234_5678);
    checkValue("t4_instr", instr, 32'h1234_5678);
    ackWith(32'hDEAD_BEEF);
    checkValue("t4_stray_ack", instr, 32'h1234_5678);
    advanceWith(2'b11, 1'b0, 32'hFFFF_FFFC);
    ackWith(32'h0);
    advanceWith(2'b00, 1'b0, 32'h0);
    checkValue("t4_wrap_pc", pc, 32'h0000_0000);

    // Reset coinciding with an ack
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0);
    checkValue("t5_valid", 32'(instr_valid), 32'h0);
    checkValue("t5_instr", instr, 32'h0);
    checkValue("t5_pc", pc, RESET_PC);
    checkValue("t5_req", 32'(imem_req), 32'h0);

    // Misaligned register target
    ackWith(32'h0);
    advanceWith(2'b11, 1'b0, 32'h0000_3002);
`ifdef IFETCH_ALIGN_CHECK_EN
    checkValue("t6_addr_err", 32'(addr_err), 32'h1);
    checkValue("t6_req", 32'(imem_req), 32'h0);
    ackWith(32'h1111_1111);
    advanceWith(2'b00, 1'b0, 32'h0);
    checkValue("t6_sticky", 32'(addr_err), 32'h1);
    checkValue("t6_pc", pc, 32'h0000_3002);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    checkValue("t6_cleared", 32'(addr_err), 32'h0);
`else
    checkValue("t6_pc", pc, 32'h0000_3000);
    checkValue("t6_addr_err", 32'(addr_err), 32'h0);
    checkValue("t6_req", 32'(imem_req), 32'h1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] jt;
      jt = $urandom();
      if ($urandom_range(0, 7) != 0) jt = jt & ~32'h3;
      applyStimulus(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 1)), $urandom(), 2'($urandom_range(0, 3)),
                    logic'($urandom_range(0, 1)), jt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
